// File: rtl/vector_store_unit.sv
// Vector store unit: writes one packed vector into byte-wide memory, one lane per cycle.
// Optional per-lane write mask enabled by defining VSTORE_MASK_EN.
module vector_store_unit #(
    parameter int unsigned elementSize = 8,
    parameter int unsigned vectorSize  = 8,
    parameter int unsigned addrWidth   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              inValid,
    output logic                              inReady,
    input  logic [elementSize*vectorSize-1:0] vectorData,
    input  logic [addrWidth-1:0]              baseAddr,
    input  logic [addrWidth-1:0]              stride,
`ifdef VSTORE_MASK_EN
    input  logic [vectorSize-1:0]             laneMask,
`endif
    output logic                              memWe,
    output logic [addrWidth-1:0]              memAddr,
    output logic [elementSize-1:0]            memData,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned vecWidth  = elementSize * vectorSize;
    localparam int unsigned laneWidth = (vectorSize > 1) ? $clog2(vectorSize) : 1;
    localparam logic [laneWidth-1:0] lastLane = laneWidth'(vectorSize - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t               state;
    logic [laneWidth-1:0] lane;
    logic [vecWidth-1:0]  vec_q;
    logic [addrWidth-1:0] stride_q;
`ifdef VSTORE_MASK_EN
    logic [vectorSize-1:0] mask_q;
`endif

    // Lane 0 is issued straight from the inputs at acceptance; vec_q holds the
    // remaining lanes left-aligned so the next element is always at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lane     <= '0;
            vec_q    <= '0;
            stride_q <= '0;
`ifdef VSTORE_MASK_EN
            mask_q   <= '0;
`endif
            inReady  <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memData  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inValid && inReady) begin
                        state    <= WRITE;
                        lane     <= '0;
                        inReady  <= 1'b0;
                        busy     <= 1'b1;
                        memAddr  <= baseAddr;
                        memData  <= vectorData[vecWidth-1 -: elementSize];
                        vec_q    <= vectorData << elementSize;
                        stride_q <= stride;
`ifdef VSTORE_MASK_EN
                        memWe    <= laneMask[0];
                        mask_q   <= laneMask >> 1;
`else
                        memWe    <= 1'b1;
`endif
                    end else begin
                        inReady <= 1'b1;
                    end
                end
                WRITE: begin
                    if (lane == lastLane) begin
                        state <= DONE;
                        memWe <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        lane    <= lane + 1'b1;
                        memAddr <= memAddr + stride_q;
                        memData <= vec_q[vecWidth-1 -: elementSize];
                        vec_q   <= vec_q << elementSize;
`ifdef VSTORE_MASK_EN
                        memWe   <= mask_q[0];
                        mask_q  <= mask_q >> 1;
`else
                        memWe   <= 1'b1;
`endif
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    inReady <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    memWe   <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    inReady <= 1'b0;
                end
            endcase
        end
    end

    // Write strobe must never escape the WRITE state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(memWe && (state != WRITE)))
                else $error("memWe asserted outside WRITE");
        end
    end

endmodule

// File: doc/vector_store_unit.md
# vector_store_unit

Write-back end of the vector datapath: accepts one packed vector result (as produced by the vector ALU) together with a base address and stride, and stores it element by element into a byte-wide data memory. It sits between the vector ALU result register and the data-memory write port and is the counterpart of the operand path that feeds the ALU. One element is written per cycle through a small FSM, with a valid/ready handshake on the input side.

## Interface
Parameters:
- elementSize, 8, bits per lane; also the memory data width
- vectorSize, 8, lanes per vector
- addrWidth, 8, memory address width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- inValid  in  1  vector/address/stride present
- inReady  out  1  unit can accept a vector
- vectorData  in  elementSize*vectorSize  packed vector; lane 0 = most-significant element, lane vectorSize-1 = least-significant
- baseAddr  in  addrWidth  address of lane 0
- stride  in  addrWidth  address increment between lanes (unsigned)
- laneMask  in  vectorSize  per-lane write enable, bit i = lane i (present only with VSTORE_MASK_EN)
- memWe  out  1  memory write strobe
- memAddr  out  addrWidth  memory write address
- memData  out  elementSize  memory write data
- busy  out  1  high in WRITE and DONE
- done  out  1  one-cycle pulse after last lane

## Operation
- States: IDLE, WRITE, DONE. Reset state IDLE.
- IDLE: inReady=1. inValid&inReady at an edge: capture vectorData, baseAddr, stride (and laneMask), lane counter=0, address register=baseAddr, go WRITE.
- WRITE: one lane per cycle; memData = lane element, memAddr = address register, memWe=1 (with macro: memWe = captured laneMask bit). Each edge: lane+1, address += stride. At lane vectorSize-1, go DONE.
- DONE: done=1, memWe=0, inReady=0; next edge go IDLE.
- Address arithmetic modulo 2^addrWidth; wrap-around is silent. stride=0 writes all lanes to baseAddr; last lane's value remains.
- Inputs outside an accepted handshake are ignored; captured values are stable for the whole store even if inputs change.
- inValid while not IDLE is held off (inReady=0); no queueing.

## Timing
- All outputs registered. Reset values: inReady=0, memWe=0, memAddr=0, memData=0, busy=0, done=0.
- inReady forced 0 while rst=1; a handshake during reset is ignored. inReady=1 from the first cycle after rst deasserts.
- Acceptance at edge E0: lane i drives memWe/memAddr/memData in the cycle between E(i) and E(i+1), sampled by memory at E(i+1), i=0..vectorSize-1.
- done high in cycle after E(vectorSize); inReady high from E(vectorSize+1). Throughput: one vector per vectorSize+2 cycles.
- rst asserted mid-store: at that edge return to IDLE, all outputs to reset values; remaining lanes not written; no done pulse.
- memWe never asserted outside WRITE.

## Configuration
- VSTORE_MASK_EN defined: laneMask port exists, captured at acceptance; masked lanes (bit 0) still consume their cycle and advance the address but hold memWe=0. Timing unchanged.
- Undefined: no laneMask port; memWe=1 for every lane in WRITE.

## Test plan
- Reset then idle: rst high 3 cycles with inValid=1 -> no memWe, outputs 0; after release inReady=1 next cycle.
- Basic store: vectorData=64'h1122334455667788, baseAddr=8'h10, stride=1 -> writes 11@10,22@11,...,88@17 on 8 consecutive cycles, done pulse on cycle 9, inReady on cycle 10.
- Stride and wrap: baseAddr=8'hFC, stride=2, data 64'hFFFFFFFFFFFFFFFF -> addresses FC,FE,00,02,04,06,08,0A, all data FF.
- Stride 0 and input hold: baseAddr=8'h20, stride=0, inputs changed during store and inValid held high -> 8 writes to 20 with captured bytes, second vector accepted only after done.
- Reset mid-store: rst asserted after lane 3 written -> no further memWe, no done, IDLE next cycle, new store proceeds normally.
- Mask (VSTORE_MASK_EN): laneMask=8'b10100101, base 8'h00, stride 1 -> memWe only at addresses 00,02,05,07; done still at cycle 9.
